// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin bus arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping 7->0, so the previous winner has lowest priority.
module rr_picker
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + i[IDX_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// Eight-requester round-robin bus arbiter with hold-time preemption and a
// one-cycle bus turnaround between owners.
//
//   state | meaning
//   IDLE  | no owner, arbitrate every cycle
//   BUSY  | grant active, hold counter running
//   TURN  | one dead cycle after release/preempt, arbitrate again
module bus_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   select,
  output logic               valid,
  output logic               preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   select_q, select_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               valid_q, valid_d;
  logic               preempt_q, preempt_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               owner_req;
  logic               others_req;

  rr_picker u_picker (
    .req    (req),
    .last   (last_q),
    .found  (found),
    .winner (winner)
  );

  assign owner_req  = |(req & grant_q);
  assign others_req = |(req & ~grant_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    select_d   = select_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    valid_d    = valid_q;
    preempt_d  = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = IDLE;
        if (found) begin
          state_d         = BUSY;
          grant_d[winner] = 1'b1;
          valid_d         = 1'b1;
          select_d        = winner;
          last_d          = winner;
          hold_cnt_d      = '0;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          state_d = TURN;
          grant_d = '0;
          valid_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST && others_req) begin
          // Timeout only when someone else is waiting; a lone owner keeps the bus.
          state_d   = TURN;
          grant_d   = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      select_q   <= '0;
      last_q     <= 3'd7;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      select_q   <= select_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign select  = select_q;
  assign valid   = valid_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Self-checking bench for bus_arbiter_8: directed vector table, rotation and
// hold sequences, then randomized traffic against an abstract reference model.
module tb_bus_arbiter_8;

  localparam int MH = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] select;
  logic       valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .grant   (grant),
    .select  (select),
    .valid   (valid),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = nobody), cycles owned so far, last winner.
  int m_owner, m_last, m_sel, m_held;
  bit m_pre;

  function automatic void model_step(input logic [7:0] r, input logic rn);
    bit found;
    bit others;
    if (!rn) begin
      m_owner = -1; m_last = 7; m_sel = 0; m_held = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && r[(m_last + k) % 8]) begin
          found   = 1;
          m_owner = (m_last + k) % 8;
        end
      end
      if (found) begin
        m_last = m_owner; m_sel = m_owner; m_held = 1;
      end
    end else begin
      others = (r & ~(8'd1 << m_owner)) != 8'd0;
      if (!r[m_owner]) m_owner = -1;
      else if (m_held >= MH && others) begin
        m_owner = -1; m_pre = 1;
      end else m_held++;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step(req, reset_n);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk({tag, ".grant"},   {24'd0, grant},   {24'd0, eg});
    chk({tag, ".select"},  {29'd0, select},  m_sel);
    chk({tag, ".valid"},   {31'd0, valid},   {31'd0, m_owner >= 0});
    chk({tag, ".preempt"}, {31'd0, preempt}, {31'd0, m_pre});
    chk({tag, ".onehot"},  {31'd0, $onehot0(grant)}, 32'd1);
    chk({tag, ".gsel"},    {31'd0, grant[select]},   {31'd0, valid});
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       p;
  } vec_t;

  vec_t vecs[22];

  initial begin
    reset_n = 1'b0;
    req     = 8'h00;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h81, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'h09, 8'h00, 3'd0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 8'hFF, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};

    step();
    for (int i = 0; i < 22; i++) begin
      reset_n = vecs[i].rst_n;
      req     = vecs[i].req;
      step();
      chk($sformatf("vec%0d.grant", i),   {24'd0, grant},   {24'd0, vecs[i].g});
      chk($sformatf("vec%0d.select", i),  {29'd0, select},  {29'd0, vecs[i].s});
      chk($sformatf("vec%0d.valid", i),   {31'd0, valid},   {31'd0, vecs[i].v});
      chk($sformatf("vec%0d.preempt", i), {31'd0, preempt}, {31'd0, vecs[i].p});
    end

    // Full rotation: every owner holds two cycles then releases for one edge.
    reset_n = 1'b0; req = 8'h00; step();
    reset_n = 1'b1; req = 8'hFF; step();
    for (int i = 0; i <= 8; i++) begin
      chk($sformatf("rot%0d.grant", i), {24'd0, grant}, {24'd0, 8'd1 << (i % 8)});
      chk($sformatf("rot%0d.select", i), {29'd0, select}, i % 8);
      if (i == 8) break;
      step();
      chk($sformatf("rot%0d.hold", i), {24'd0, grant}, {24'd0, 8'd1 << (i % 8)});
      req = 8'hFF & ~(8'd1 << (i % 8));
      step();
      chk($sformatf("rot%0d.turn", i), {30'd0, grant == 8'd0, valid}, 32'd2);
      req = 8'hFF;
      step();
    end

    // Lone requester past the hold limit keeps the bus with no preempt.
    reset_n = 1'b0; req = 8'h00; step();
    reset_n = 1'b1; req = 8'h04; step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("lone%0d.grant", i),   {24'd0, grant},   32'h04);
      chk($sformatf("lone%0d.preempt", i), {31'd0, preempt}, 32'd0);
      step();
    end

    // Randomized traffic against the model.
    reset_n = 1'b0; req = 8'h00; step();
    chk_model("rst");
    reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) req = 8'($urandom);
      reset_n = ($urandom_range(0, 79) != 0);
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_8.md
BUS_ARBITER_8 -- requirements
Module: Bus_Arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles before forced rotation when others are waiting; legal range 2..255.
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, synchronous, active-low.
REQ-004 Req  input  8  level request per requester; bit i = requester i wants the shared 16-bit bus.
REQ-005 Grant  output  8  one-hot registered grant; all-zero when no owner.
REQ-006 Select  output  3  binary index of current or most recent owner; drives the 8:1 bus mux select.
REQ-007 Valid  output  1  high while a grant is active (Grant != 0).
REQ-008 Preempt  output  1  single-cycle pulse on the cycle a grant is revoked by timeout.

Function
REQ-009 FSM states: IDLE, BUSY, TURN; registered state; outputs derived from registers only.
REQ-010 Arbitration occurs in IDLE and TURN: if Req != 0, winner = first set bit scanning upward from (Last+1) mod 8, wrapping 7->0.
REQ-011 Grant latency: Req sampled high in cycle N (IDLE/TURN) -> Grant, Valid, Select valid in cycle N+1; state BUSY.
REQ-012 On grant: Last <= winner; Select <= winner; HoldCnt <= 0.
REQ-013 IDLE with Req == 0: remain IDLE; Grant = 0, Valid = 0.
REQ-014 BUSY: HoldCnt increments each cycle, saturating at MAX_HOLD-1.
REQ-015 BUSY, Req[owner] == 0: next state TURN; Grant cleared next cycle (voluntary release).
REQ-016 BUSY, Req[owner] == 1, HoldCnt == MAX_HOLD-1, any other Req bit set: next state TURN, Preempt = 1 in the TURN cycle.
REQ-017 BUSY, HoldCnt == MAX_HOLD-1, no other requester: owner retains grant indefinitely; no preempt.
REQ-018 TURN lasts exactly one cycle with Grant = 0, Valid = 0 (bus turnaround); arbitrates per REQ-010 -> BUSY, else IDLE.
REQ-019 Preempted owner still requesting competes normally; rotation guarantees every other requester is served first.
REQ-020 Select holds last owner index in IDLE/TURN; never changes except on a new grant.
REQ-021 Grant is always one-hot or zero; Grant[Select] == Valid in every cycle.
REQ-022 Requests arriving while BUSY are not lost; they are considered at the next TURN.

Reset
REQ-023 Reset_n low at a rising edge: state IDLE, Grant 0, Valid 0, Preempt 0, Select 0, HoldCnt 0, Last 7 (requester 0 top priority first).
REQ-024 Reset asserted mid-grant takes priority over all transitions; Grant is 0 in the cycle after the reset edge.
REQ-025 First arbitration possible in the first cycle with Reset_n high.

Structure
REQ-026 Shared package Arb_Pkg holds: state enum (IDLE, BUSY, TURN), NUM_REQ = 8, IDX_W = 3.
REQ-027 Sub-module Rr_Picker (combinational): inputs Req[7:0], Last[2:0]; outputs Found, Winner[2:0]; instantiated once.
REQ-028 Select connects directly to the existing 8:1 mux select; no additional output logic.

Verification
REQ-029 Reset then Req=8'h01 from cycle 0 -> Grant=8'h01, Select=0, Valid=1 at cycle 1; Req dropped at cycle 5 -> TURN at 6, IDLE at 7.
REQ-030 Req=8'hFF constant, owners release after 2 cycles each -> grant order 0,1,...,7,0 with one TURN cycle between each.
REQ-031 MAX_HOLD=4, Req[3] held, Req[5] raised at cycle 2 -> Preempt pulse at TURN after 4 BUSY cycles, Grant=8'h20 next cycle.
REQ-032 MAX_HOLD=4, only Req[2] held for 20 cycles -> Grant=8'h04 continuous, Preempt never asserted.
REQ-033 Last=6, Req=8'h81 simultaneously -> winner 7 (wrap order), then 0.
REQ-034 Reset_n low during BUSY with Req=8'hFF -> Grant=0, Select=0 next cycle; then requester 0 granted first.
